// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: RISC-V debug module system bus access sequencer.
// Define DM_SBA_ALIGN_CHECK_EN to reject misaligned accesses with sberror=3.
module dm_sba_ctrl #(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sberror_clr_i,
  input  logic                  sbbusyerror_clr_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic [2:0]            sberror_o,
  output logic                  master_req_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i
);
  localparam int NB = BusWidth / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT_READ, WAIT_WRITE} state_e;
  state_e state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d, data_q, data_d;
  logic [2:0] acc_q, acc_d, err_q, err_d;
  logic busyerr_q, busyerr_d, valid_q, valid_d;
  logic [BusWidth-1:0] amask, aligned, start_addr, rmask;
  logic [OW-1:0] off;
  logic start_rd, start_wr, trig, size_bad, align_bad;
  int nbytes;
  // Lane geometry of the access in flight; acc_q is frozen at start so the bus stays stable.
  always_comb begin
    nbytes = 1 << acc_q;
    amask = (BusWidth'(1) << acc_q) - BusWidth'(1);
    aligned = addr_q & ~amask;
    off = aligned[OW-1:0];
    for (int i = 0; i < NB; i++) begin
      master_be_o[i] = master_req_o && (i >= int'(off)) && (i < int'(off) + nbytes);
      master_wdata_o[8*i +: 8] = data_q[8*(i % nbytes) +: 8];
      rmask[8*i +: 8] = (i < nbytes) ? 8'hff : 8'h00;
    end
  end
  always_comb begin
    trig = sbaddress_write_valid_i | sbdata_write_valid_i | sbdata_read_valid_i;
    start_addr = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    start_rd = (sbaddress_write_valid_i & sbreadonaddr_i) | (sbdata_read_valid_i & sbreadondata_i);
    start_wr = sbdata_write_valid_i;
    size_bad = sbaccess_i > 3'(OW);
`ifdef DM_SBA_ALIGN_CHECK_EN
    align_bad = |(start_addr & ((BusWidth'(1) << sbaccess_i) - BusWidth'(1)));
`else
    align_bad = 1'b0;
`endif
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    acc_d = acc_q;
    err_d = err_q & ~sberror_clr_i;
    busyerr_d = busyerr_q & ~sbbusyerror_clr_i;
    valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (sbaddress_write_valid_i) addr_d = sbaddress_i;
      if (sbdata_write_valid_i) data_d = sbdata_i;
      if ((start_rd | start_wr) && err_q == 3'd0 && !busyerr_q) begin
        if (size_bad) err_d = 3'd4;
        else if (align_bad) err_d = 3'd3;
        else begin
          state_d = start_wr ? WRITE : READ;
          acc_d = sbaccess_i;
        end
      end
    end else if (trig) busyerr_d = 1'b1;
    if ((state_q == READ || state_q == WRITE) && master_gnt_i)
      state_d = (state_q == READ) ? WAIT_READ : WAIT_WRITE;
    if ((state_q == WAIT_READ || state_q == WAIT_WRITE) && master_r_valid_i) begin
      state_d = IDLE;
      if (master_r_err_i) begin
        if (err_q == 3'd0) err_d = 3'd2;
      end else begin
        if (state_q == WAIT_READ) begin
          data_d = (master_r_rdata_i >> {off, 3'b000}) & rmask;
          valid_d = 1'b1;
        end
        if (sbautoincrement_i) addr_d = addr_q + (BusWidth'(1) << acc_q);
      end
    end
    if (!dmactive_i) begin
      state_d = IDLE;
      addr_d = '0;
      data_d = '0;
      acc_d = '0;
      err_d = '0;
      busyerr_d = 1'b0;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      acc_q <= '0;
      err_q <= '0;
      busyerr_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      acc_q <= acc_d;
      err_q <= err_d;
      busyerr_q <= busyerr_d;
      valid_q <= valid_d;
    end
  end
  assign sbaddress_o = addr_q;
  assign sbdata_o = data_q;
  assign sbdata_valid_o = valid_q;
  assign sbbusy_o = state_q != IDLE;
  assign sbbusyerror_o = busyerr_q;
  assign sberror_o = err_q;
  assign master_req_o = state_q == READ || state_q == WRITE;
  assign master_we_o = state_q == WRITE;
  assign master_add_o = aligned;
endmodule

// File: tb/tb_dm_sba_ctrl.sv
// tb_dm_sba_ctrl: table-driven check of dm_sba_ctrl at BusWidth=32.
module tb_dm_sba_ctrl;
  logic clk = 0, rst_n = 0, dmactive = 0;
  logic [31:0] sbaddress = 0, sbdata = 0, rdata = 0;
  logic addr_wv = 0, data_wv = 0, data_rv = 0;
  logic [2:0] sbaccess = 0, err_clr = 0;
  logic roa = 0, rod = 0, inc = 0, busy_clr = 0;
  logic gnt = 0, r_valid = 0, r_err = 0;
  logic [31:0] sbaddress_o, sbdata_o, madd, mwdata;
  logic sbdata_valid, sbbusy, sbbusyerr, mreq, mwe;
  logic [2:0] sberr;
  logic [3:0] mbe;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dm_sba_ctrl #(.BusWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .sbaddress_i(sbaddress), .sbaddress_write_valid_i(addr_wv),
    .sbdata_i(sbdata), .sbdata_write_valid_i(data_wv), .sbdata_read_valid_i(data_rv),
    .sbaccess_i(sbaccess), .sbreadonaddr_i(roa), .sbreadondata_i(rod),
    .sbautoincrement_i(inc), .sberror_clr_i(err_clr), .sbbusyerror_clr_i(busy_clr),
    .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid),
    .sbbusy_o(sbbusy), .sbbusyerror_o(sbbusyerr), .sberror_o(sberr),
    .master_req_o(mreq), .master_we_o(mwe), .master_add_o(madd),
    .master_wdata_o(mwdata), .master_be_o(mbe), .master_gnt_i(gnt),
    .master_r_valid_i(r_valid), .master_r_err_i(r_err), .master_r_rdata_i(rdata)
  );
  typedef struct {
    logic        wr;
    logic [2:0]  acc;
    logic        inc;
    logic [31:0] addr, wdata, rdata;
    logic        rerr, exp_req;
    logic [31:0] exp_madd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_sbdata, exp_sbaddr;
    logic [2:0]  exp_err;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic clear_errs();
    @(negedge clk);
    err_clr = 3'b111;
    busy_clr = 1;
    @(negedge clk);
    err_clr = 0;
    busy_clr = 0;
  endtask
  task automatic run_vec(input vec_t v);
    clear_errs();
    sbaccess = v.acc;
    inc = v.inc;
    sbaddress = v.addr;
    addr_wv = 1;
    roa = !v.wr;
    if (v.wr) begin
      @(negedge clk);
      addr_wv = 0;
      sbdata = v.wdata;
      data_wv = 1;
    end
    @(negedge clk);
    addr_wv = 0;
    data_wv = 0;
    chk("req", mreq, v.exp_req);
    if (v.exp_req) begin
      chk("madd", madd, v.exp_madd);
      chk("be", mbe, v.exp_be);
      chk("we", mwe, v.wr);
      if (v.wr) chk("wdata", mwdata, v.exp_wd);
      gnt = 1;
      @(negedge clk);
      gnt = 0;
      chk("busy_wait", sbbusy, 1);
      chk("req_wait", mreq, 0);
      r_valid = 1;
      rdata = v.rdata;
      r_err = v.rerr;
      @(negedge clk);
      r_valid = 0;
      r_err = 0;
    end
    chk("busy_done", sbbusy, 0);
    chk("valid", sbdata_valid, !v.wr && v.exp_req && !v.rerr);
    chk("sbdata", sbdata_o, v.exp_sbdata);
    chk("sbaddr", sbaddress_o, v.exp_sbaddr);
    chk("sberr", sberr, v.exp_err);
    roa = 0;
  endtask
  initial begin
    vecs[0]  = '{0, 2, 1, 32'h1000, 0, 32'hDEADBEEF, 0, 1, 32'h1000, 4'b1111, 0, 32'hDEADBEEF, 32'h1004, 0};
    vecs[1]  = '{1, 0, 0, 32'h2003, 32'h5A, 0, 0, 1, 32'h2003, 4'b1000, 32'h5A5A5A5A, 32'h5A, 32'h2003, 0};
    vecs[2]  = '{0, 0, 1, 32'h2002, 0, 32'h11223344, 0, 1, 32'h2002, 4'b0100, 0, 32'h22, 32'h2003, 0};
    vecs[3]  = '{0, 1, 1, 32'h3002, 0, 32'hAABBCCDD, 0, 1, 32'h3002, 4'b1100, 0, 32'hAABB, 32'h3004, 0};
    vecs[4]  = '{1, 1, 1, 32'h4000, 32'h1234ABCD, 0, 0, 1, 32'h4000, 4'b0011, 32'hABCDABCD, 32'h1234ABCD, 32'h4002, 0};
    vecs[5]  = '{0, 2, 1, 32'h5000, 0, 32'hFFFFFFFF, 1, 1, 32'h5000, 4'b1111, 0, 32'h1234ABCD, 32'h5000, 2};
    vecs[6]  = '{0, 3, 0, 32'h6000, 0, 0, 0, 0, 0, 0, 0, 32'h1234ABCD, 32'h6000, 4};
`ifdef DM_SBA_ALIGN_CHECK_EN
    vecs[7]  = '{0, 2, 0, 32'h1002, 0, 0, 0, 0, 0, 0, 0, 32'h1234ABCD, 32'h1002, 3};
`else
    vecs[7]  = '{0, 2, 0, 32'h1002, 0, 32'hCAFEF00D, 0, 1, 32'h1000, 4'b1111, 0, 32'hCAFEF00D, 32'h1002, 0};
`endif
    vecs[8]  = '{0, 2, 1, 32'hFFFFFFFC, 0, 32'h01020304, 0, 1, 32'hFFFFFFFC, 4'b1111, 0, 32'h01020304, 32'h0, 0};
    vecs[9]  = '{1, 2, 0, 32'h7000, 32'h89ABCDEF, 0, 0, 1, 32'h7000, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF, 32'h7000, 0};
    vecs[10] = '{1, 0, 1, 32'h8001, 32'h77, 0, 0, 1, 32'h8001, 4'b0010, 32'h77777777, 32'h77, 32'h8002, 0};
    repeat (3) @(negedge clk);
    rst_n = 1;
    dmactive = 1;
    @(negedge clk);
    chk("rst_busy", sbbusy, 0);
    chk("rst_req", mreq, 0);
    chk("rst_we", mwe, 0);
    chk("rst_be", mbe, 0);
    chk("rst_madd", madd, 0);
    chk("rst_wdata", mwdata, 0);
    chk("rst_sberr", sberr, 0);
    chk("rst_busyerr", sbbusyerr, 0);
    chk("rst_sbaddr", sbaddress_o, 0);
    chk("rst_sbdata", sbdata_o, 0);
    chk("rst_valid", sbdata_valid, 0);
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    // Bus error then a data write that must be blocked.
    run_vec('{0, 2, 1, 32'hB000, 0, 32'h0, 1, 1, 32'hB000, 4'b1111, 0, 32'h77, 32'hB000, 2});
    @(negedge clk);
    sbdata = 32'h55;
    data_wv = 1;
    @(negedge clk);
    data_wv = 0;
    chk("blk_req", mreq, 0);
    chk("blk_busy", sbbusy, 0);
    chk("blk_sbdata", sbdata_o, 32'h55);
    chk("blk_sberr", sberr, 2);
    err_clr = 3'b111;
    @(negedge clk);
    err_clr = 0;
    chk("clr_sberr", sberr, 0);
    // Busy error while the request waits for grant, then a trigger in the completion cycle.
    clear_errs();
    sbaccess = 2;
    inc = 0;
    roa = 1;
    sbaddress = 32'h9000;
    addr_wv = 1;
    @(negedge clk);
    addr_wv = 0;
    roa = 0;
    chk("bz_req", mreq, 1);
    sbdata = 32'hBAD;
    data_wv = 1;
    @(negedge clk);
    data_wv = 0;
    chk("bz_err", sbbusyerr, 1);
    chk("bz_sbdata", sbdata_o, 32'h55);
    chk("bz_req_held", mreq, 1);
    busy_clr = 1;
    @(negedge clk);
    busy_clr = 0;
    chk("bz_clr", sbbusyerr, 0);
    gnt = 1;
    @(negedge clk);
    gnt = 0;
    r_valid = 1;
    rdata = 32'h600DD00D;
    sbdata = 32'hBAD2;
    data_wv = 1;
    @(negedge clk);
    r_valid = 0;
    data_wv = 0;
    chk("cc_busyerr", sbbusyerr, 1);
    chk("cc_sbdata", sbdata_o, 32'h600DD00D);
    chk("cc_valid", sbdata_valid, 1);
    chk("cc_busy", sbbusy, 0);
    chk("cc_sbaddr", sbaddress_o, 32'h9000);
    chk("cc_req", mreq, 0);
    // Abandon a read with dmactive low; its late response must be ignored.
    clear_errs();
    sbaccess = 2;
    inc = 1;
    roa = 1;
    sbaddress = 32'hA000;
    addr_wv = 1;
    @(negedge clk);
    addr_wv = 0;
    roa = 0;
    gnt = 1;
    @(negedge clk);
    gnt = 0;
    chk("da_busy", sbbusy, 1);
    dmactive = 0;
    @(negedge clk);
    chk("da_req", mreq, 0);
    chk("da_busy_off", sbbusy, 0);
    chk("da_sbaddr", sbaddress_o, 0);
    chk("da_sbdata", sbdata_o, 0);
    r_valid = 1;
    rdata = 32'h12345678;
    @(negedge clk);
    r_valid = 0;
    dmactive = 1;
    chk("da_valid", sbdata_valid, 0);
    chk("da_sbdata2", sbdata_o, 0);
    @(negedge clk);
    chk("da_valid2", sbdata_valid, 0);
    chk("da_busy2", sbbusy, 0);
    chk("da_sbaddr2", sbaddress_o, 0);
    chk("da_sberr", sberr, 0);
    chk("da_busyerr", sbbusyerr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
